uart_result_tx: RTL and testbench

UART_RESULT_TX -- requirements
Module: uart_result_tx

---
 rtl/uart_result_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_result_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_result_tx
// Summary  : Byte FIFO feeding an 8N1 UART transmitter with back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_result_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enb,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          tx_data,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int                c_AW        = $clog2(FIFO_DEPTH);
   localparam int                c_BW        = $clog2(CLKS_PER_BIT);
   localparam logic [c_BW-1:0]   c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
   localparam logic [c_AW:0]     c_FULL      = (c_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;
   logic            w_push;
   logic            w_pop;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [c_BW-1:0] r_baud;
   logic [c_BW-1:0] w_baud_nxt;
   logic [2:0]      r_bit_idx;
   logic [2:0]      w_idx_nxt;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_nxt;
   logic            r_tx;
   logic            w_tx_nxt;
   logic            r_busy;
   logic            w_baud_last;
   logic            w_can_start;

   assign in_ready    = (r_count < c_FULL) && !rst;
   assign w_push      = in_valid && in_ready;
   assign fifo_count  = r_count;
   assign tx_data     = r_tx;
   assign busy        = r_busy;
   assign w_baud_last = (r_baud == c_BAUD_LAST);
   assign w_can_start = enb && (r_count != '0);

   // Storage has no reset; w_push is already suppressed while rst is high.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_baud    <= w_baud_nxt;
         r_bit_idx <= w_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_tx      <= w_tx_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
      end
   end

   // tx is computed one cycle ahead so the line itself comes straight from a flop.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_idx_nxt   = r_bit_idx;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_tx_nxt = 1'b1;
            if (w_can_start) begin
               w_pop       = 1'b1;
               w_shift_nxt = r_mem[r_rd_ptr];
               w_baud_nxt  = '0;
               w_idx_nxt   = '0;
               w_tx_nxt    = 1'b0;
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (w_baud_last) begin
               w_baud_nxt  = '0;
               w_tx_nxt    = r_shift[0];
               w_state_nxt = ST_DATA;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         ST_DATA: begin
            if (w_baud_last) begin
               w_baud_nxt = '0;
               if (r_bit_idx == 3'd7) begin
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = ST_STOP;
               end else begin
                  w_idx_nxt   = r_bit_idx + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_tx_nxt    = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         ST_STOP: begin
            if (w_baud_last) begin
               w_baud_nxt = '0;
               if (w_can_start) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = r_mem[r_rd_ptr];
                  w_idx_nxt   = '0;
                  w_tx_nxt    = 1'b0;
                  w_state_nxt = ST_START;
               end else begin
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         default: begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_result_tx
// Summary  : Directed bench for uart_result_tx with a serial-line decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_result_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       enb      = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       tx_data;
   logic       busy;
   logic [2:0] fifo_count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] rx_q [$];
   logic       mon_en = 1'b0;

   uart_result_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .enb(enb), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .tx_data(tx_data), .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   // Serial decoder: samples each bit mid-way and queues received bytes.
   initial begin
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      b    = 8'h00;
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (!rst && prev && !tx_data) begin
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx_data;
            end
            repeat (CPB) @(negedge clk);
            rx_q.push_back(b);
         end
         prev = tx_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   task automatic wait_idle(input int max_cycles, input string name);
      int i;
      i = 0;
      while ((busy || fifo_count != 3'd0) && i < max_cycles) begin
         @(negedge clk);
         i++;
      end
      n_checks++;
      if (busy || fifo_count != 3'd0) begin
         n_fail++;
         $display("FAIL %s: still busy=%b count=%0d after %0d cycles, required idle", name, busy, fifo_count, max_cycles);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enb = 1'b0; in_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (tx_data !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
      mon_en = 1'b1;
   endtask

   task automatic test_single();
      logic [9:0] frame;
      logic       exp;
      int         busy_cycles;
      frame = 10'b11_0100_1010;
      rx_q.delete();
      enb = 1'b1;
      in_valid = 1'b1; in_data = 8'hA5;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_pushed: got %0d required 1", fifo_count); end
      n_checks++; if (tx_data !== 1'b1) begin n_fail++; $display("FAIL single_pre_tx: got %b required 1", tx_data); end
      busy_cycles = 0;
      for (int k = 1; k <= 44; k++) begin
         @(negedge clk);
         if (busy) busy_cycles++;
         exp = (k <= 40) ? frame[(k-1)/4] : 1'b1;
         n_checks++;
         if (tx_data !== exp) begin n_fail++; $display("FAIL single_tx k=%0d: got %b required %b", k, tx_data, exp); end
         if (k == 1) begin
            n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_popped: got %0d required 0", fifo_count); end
         end
      end
      n_checks++; if (busy_cycles != 40) begin n_fail++; $display("FAIL single_busy_len: got %0d required 40", busy_cycles); end
      n_checks++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
         n_fail++; $display("FAIL single_rx: got %0d bytes first %h required 1 byte a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] frames;
      logic        exp;
      int          busy_cycles;
      frames = 20'b1111111110_1000000000;
      rx_q.delete();
      enb = 1'b1;
      in_valid = 1'b1; in_data = 8'h00;
      @(negedge clk);
      in_data = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL push_pop_count: got %0d required 1", fifo_count); end
      n_checks++; if (tx_data !== 1'b0) begin n_fail++; $display("FAIL b2b_start: got %b required 0", tx_data); end
      busy_cycles = busy ? 1 : 0;
      for (int k = 2; k <= 84; k++) begin
         @(negedge clk);
         if (busy) busy_cycles++;
         exp = (k <= 80) ? frames[(k-1)/4] : 1'b1;
         n_checks++;
         if (tx_data !== exp) begin n_fail++; $display("FAIL b2b_tx k=%0d: got %b required %b", k, tx_data, exp); end
         if (k == 41) begin
            n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL b2b_second_pop: got %0d required 0", fifo_count); end
         end
      end
      n_checks++; if (busy_cycles != 80) begin n_fail++; $display("FAIL b2b_busy_len: got %0d required 80", busy_cycles); end
      n_checks++;
      if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
         n_fail++; $display("FAIL b2b_rx: got %0d bytes required 00 ff", rx_q.size());
      end
   endtask

   task automatic test_full_fifo();
      logic [7:0] d [5];
      d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      rx_q.delete();
      enb = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = d[i];
         @(negedge clk);
      end
      in_data = d[4];
      n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d required 4", fifo_count); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
      @(negedge clk);
      n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_hold: got %0d required 4", fifo_count); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_no_start: got %b required 0", busy); end
      enb = 1'b1;
      @(negedge clk);
      n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL full_first_pop: got %0d required 3", fifo_count); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: got %b required 1", in_ready); end
      n_checks++; if (tx_data !== 1'b0) begin n_fail++; $display("FAIL full_start_tx: got %b required 0", tx_data); end
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_fifth_push: got %0d required 4", fifo_count); end
      wait_idle(300, "full_drain");
      n_checks++;
      if (rx_q.size() != 5 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || rx_q[2] !== 8'h33 ||
          rx_q[3] !== 8'h44 || rx_q[4] !== 8'h55) begin
         n_fail++; $display("FAIL full_rx_order: got %0d bytes required 11 22 33 44 55", rx_q.size());
      end
   endtask

   task automatic test_enb_drop();
      int bad;
      rx_q.delete();
      enb = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h3C; @(negedge clk);
      in_data = 8'h5A; @(negedge clk);
      in_data = 8'h96; @(negedge clk);
      in_valid = 1'b0;
      enb = 1'b1;
      @(negedge clk);
      n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL drop_queued: got %0d required 2", fifo_count); end
      repeat (17) @(negedge clk);
      enb = 1'b0;
      n_checks++; if (tx_data !== 1'b1) begin n_fail++; $display("FAIL drop_bit3: got %b required 1", tx_data); end
      repeat (22) @(negedge clk);
      n_checks++; if (busy !== 1'b1 || tx_data !== 1'b1) begin n_fail++; $display("FAIL drop_stop: got busy=%b tx=%b required 1 1", busy, tx_data); end
      bad = 0;
      for (int k = 41; k <= 60; k++) begin
         @(negedge clk);
         if (tx_data !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd2) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL drop_held_idle: got %0d bad cycles required 0", bad); end
      n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin n_fail++; $display("FAIL drop_first_rx: got %0d bytes required 3c", rx_q.size()); end
      enb = 1'b1;
      @(negedge clk);
      n_checks++; if (tx_data !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL drop_resume: got tx=%b count=%0d required 0 1", tx_data, fifo_count); end
      wait_idle(200, "drop_drain");
      n_checks++;
      if (rx_q.size() != 3 || rx_q[1] !== 8'h5A || rx_q[2] !== 8'h96) begin
         n_fail++; $display("FAIL drop_rx_order: got %0d bytes required 3c 5a 96", rx_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      enb = 1'b1;
      in_valid = 1'b1;
      in_data = 8'hC3; @(negedge clk);
      in_data = 8'h81; @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (fifo_count !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: got count=%0d busy=%b required 1 1", fifo_count, busy); end
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (tx_data !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b required 1", tx_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d required 0", fifo_count); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b required 0", in_ready); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_release_ready: got %b required 1", in_ready); end
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (busy !== 1'b0 || tx_data !== 1'b1) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_discarded: got %0d active cycles required 0", bad); end
      repeat (40) @(negedge clk);
      rx_q.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full_fifo();
      test_enb_drop();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
